// File: rtl/lcd_ctrl_pkg.sv
// Shared types and limits for the LCD digit-update arbiter.
// States, digit-index constants and input clamp helpers.
package lcd_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_ISSUE,
    S_GAP
  } state_e;

  localparam logic [1:0] IDX_MOTOR = 2'd0;
  localparam logic [1:0] IDX_D100  = 2'd1;
  localparam logic [1:0] IDX_D10   = 2'd2;
  localparam logic [1:0] IDX_D1    = 2'd3;

  localparam logic [3:0] MOTOR_MAX = 4'd9;
  localparam logic [9:0] DISP_MAX  = 10'd999;

  function automatic logic [3:0] clamp_motor(
    input logic [3:0] id
  );
    return (id > MOTOR_MAX) ? MOTOR_MAX : id;
  endfunction

  function automatic logic [9:0] clamp_disp(
    input logic [9:0] bin
  );
    return (bin > DISP_MAX) ? DISP_MAX : bin;
  endfunction

endpackage

// File: rtl/lcd_bin2bcd3.sv
// Serial binary-to-BCD converter for 0..999, one subtraction per cycle.
// Digits are held after done until the next start.
module lcd_bin2bcd3 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [9:0] bin_i,
  output logic       done_o,
  output logic [3:0] hund_o,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  logic       act_q, act_d;
  logic [9:0] rem_q, rem_d;
  logic [3:0] hund_q, hund_d;
  logic [3:0] tens_q, tens_d;

  always_comb begin
    act_d  = act_q;
    rem_d  = rem_q;
    hund_d = hund_q;
    tens_d = tens_q;
    if (start_i) begin
      act_d  = 1'b1;
      rem_d  = bin_i;
      hund_d = 4'd0;
      tens_d = 4'd0;
    end else if (act_q) begin
      if (rem_q >= 10'd100) begin
        rem_d  = rem_q - 10'd100;
        hund_d = hund_q + 4'd1;
      end else if (rem_q >= 10'd10) begin
        rem_d  = rem_q - 10'd10;
        tens_d = tens_q + 4'd1;
      end else begin
        act_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_q  <= 1'b0;
      rem_q  <= 10'd0;
      hund_q <= 4'd0;
      tens_q <= 4'd0;
    end else begin
      act_q  <= act_d;
      rem_q  <= rem_d;
      hund_q <= hund_d;
      tens_q <= tens_d;
    end
  end

  assign done_o = act_q && (rem_q < 10'd10);
  assign hund_o = hund_q;
  assign tens_o = tens_q;
  assign ones_o = rem_q[3:0];

endmodule

// File: rtl/lcd_update_arbiter.sv
// Arbitrates motor / displacement updates onto the LCD digit-write port.
// LCD_ARB_SKIP_UNCHANGED_EN: skip digits equal to the displayed value.
module lcd_update_arbiter
  import lcd_ctrl_pkg::*;
#(
  parameter int UPDATE_GAP = 82000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       motor_valid,
  input  logic [3:0] motor_id,
  output logic       motor_ready,
  input  logic       disp_valid,
  input  logic [9:0] disp_bin,
  output logic       disp_ready,
  output logic [1:0] number_index,
  output logic [3:0] number_in,
  output logic       number_modify_en,
  output logic       busy
);

  localparam int CW = $clog2(UPDATE_GAP + 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(UPDATE_GAP - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          src_q, src_d;
  logic          last_q, last_d;
  logic [3:0]    shadow_q [4];
  logic [3:0]    shadow_d [4];

  logic          idle;
  logic          conv_start, conv_done;
  logic [3:0]    hund, tens, ones;
  logic [3:0]    cand [4];
  logic [3:0]    same;
  logic [2:0]    nx_from;
  logic          nx_found;
  logic [1:0]    nx_idx;

  lcd_bin2bcd3 u_conv (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst_n),
    .start_i (conv_start),
    .bin_i   (clamp_disp(disp_bin)),
    .done_o  (conv_done),
    .hund_o  (hund),
    .tens_o  (tens),
    .ones_o  (ones)
  );

  assign idle = (state_q == S_IDLE);

  // last_q tracks only contested grants: 1 = disp won the last tie
  assign motor_ready = sys_rst_n && idle && motor_valid
                     && (!disp_valid || last_q);
  assign disp_ready  = sys_rst_n && idle && disp_valid
                     && (!motor_valid || !last_q);

  always_comb begin
    cand[IDX_MOTOR] = clamp_motor(motor_id);
    cand[IDX_D100]  = hund;
    cand[IDX_D10]   = tens;
    cand[IDX_D1]    = ones;
  end

`ifdef LCD_ARB_SKIP_UNCHANGED_EN
  always_comb begin
    for (int i = 0; i < 4; i++) same[i] = (cand[i] == shadow_q[i]);
  end
`else
  assign same = 4'b0000;
`endif

  always_comb begin
    nx_from  = (state_q == S_GAP) ? ({1'b0, idx_q} + 3'd1) : 3'd1;
    nx_found = 1'b0;
    nx_idx   = IDX_D1;
    for (int i = 3; i >= 1; i--) begin
      if (3'(i) >= nx_from && !same[i]) begin
        nx_found = 1'b1;
        nx_idx   = 2'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    src_d      = src_q;
    last_d     = last_q;
    shadow_d   = shadow_q;
    conv_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (motor_ready) begin
          if (disp_valid) last_d = 1'b0;
          src_d = 1'b0;
          if (!same[IDX_MOTOR]) begin
            idx_d = IDX_MOTOR;
            shadow_d[IDX_MOTOR] = cand[IDX_MOTOR];
            state_d = S_ISSUE;
          end
        end else if (disp_ready) begin
          if (motor_valid) last_d = 1'b1;
          src_d      = 1'b1;
          conv_start = 1'b1;
          state_d    = S_CONVERT;
        end
      end
      S_CONVERT: begin
        if (conv_done) begin
          if (nx_found) begin
            idx_d = nx_idx;
            shadow_d[nx_idx] = cand[nx_idx];
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (src_q && nx_found) begin
            idx_d = nx_idx;
            shadow_d[nx_idx] = cand[nx_idx];
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= IDX_MOTOR;
      src_q    <= 1'b0;
      last_q   <= 1'b1;
      shadow_q <= '{default: 4'd0};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      src_q    <= src_d;
      last_q   <= last_d;
      shadow_q <= shadow_d;
    end
  end

  // shadow is loaded on the edge that starts the pulse, so it is the digit
  assign number_index     = idx_q;
  assign number_in        = shadow_q[idx_q];
  assign number_modify_en = (state_q == S_ISSUE);
  assign busy             = !idle;

endmodule

// File: doc/lcd_update_arbiter.md
LCD_UPDATE_ARBITER -- requirements
Module: lcd_update_arbiter

Interface
REQ-001 SHALL have parameter: UPDATE_GAP, 82000, minimum sys_clk cycles after each number_modify_en pulse before the next pulse or the return to IDLE (covers one full LCD RAM rewrite and screen refresh).
REQ-002 SHALL have port: sys_clk input 1 system clock (12 MHz); the single clock of the block.
REQ-003 SHALL have port: sys_rst_n input 1 asynchronous, active-low reset.
REQ-004 SHALL have port: motor_valid input 1 motor-number update request.
REQ-005 SHALL have port: motor_id input 4 motor number, 0-9; values 10-15 are clamped to 9.
REQ-006 SHALL have port: motor_ready output 1 motor request accepted when motor_valid && motor_ready.
REQ-007 SHALL have port: disp_valid input 1 displacement update request.
REQ-008 SHALL have port: disp_bin input 10 binary displacement; values above 999 are clamped to 999.
REQ-009 SHALL have port: disp_ready output 1 displacement request accepted when disp_valid && disp_ready.
REQ-010 SHALL have ports: number_index output 2, number_in output 4, number_modify_en output 1; these drive the LCD display digit-write interface.
REQ-011 SHALL have port: busy output 1, high in every state except IDLE.

Function
REQ-012 SHALL implement the states IDLE, CONVERT, ISSUE and GAP.
REQ-013 IDLE: ready is granted to at most one requester per cycle; if only one is valid, that requester gets ready; if both are valid, round-robin grants the requester not granted last.
REQ-014 SHALL latch the payload on acceptance. A requester's valid must stay high until ready; the block ignores payload changes before acceptance.
REQ-015 Motor accept: number_modify_en pulses exactly one cycle, on the cycle after acceptance, with index 0 and number_in = clamped motor_id; the FSM then enters GAP.
REQ-016 Disp accept: the FSM enters CONVERT and forms hundreds/tens/ones digits by repeated subtraction, one subtraction per cycle (100s first, then 10s). The first pulse SHALL occur no more than 20 cycles after acceptance.
REQ-017 ISSUE, disp: write hundreds to index 1, tens to index 2 and ones to index 3, in that order. Each pulse lasts one cycle and is followed by GAP.
REQ-018 GAP: count UPDATE_GAP cycles, then either issue the next pending digit or return to IDLE. Both ready outputs SHALL be low in every state except IDLE.
REQ-019 number_index and number_in SHALL be held stable from the pulse cycle through the end of the following GAP.
REQ-020 SHALL keep shadow registers of the four displayed digits, updated on every pulse.
REQ-021 Valid asserted during busy SHALL stay pending and be arbitrated on the first IDLE cycle; no request is lost.

Reset
REQ-022 On sys_rst_n low, immediately: state IDLE; all outputs 0; shadow digits 0; last grant = disp, so motor wins the first tie.
REQ-023 Reset mid-sequence SHALL abort without any further pulse; the GAP counter clears to 0.

Configuration
REQ-024 With LCD_ARB_SKIP_UNCHANGED_EN defined: a digit equal to its shadow value SHALL be skipped with no pulse and no GAP; if all digits of a request match, the FSM returns to IDLE within 2 cycles after conversion. Without the macro: every digit is always written.

Structure
REQ-025 Package lcd_ctrl_pkg SHALL hold the FSM state enum, the digit-index constants (IDX_MOTOR=0, IDX_D100=1, IDX_D10=2, IDX_D1=3) and the clamp limits (9, 999).
REQ-026 Conversion SHALL be a sub-module lcd_bin2bcd3 with a start/done handshake and hundreds, tens and ones outputs.

Verification (bench UPDATE_GAP=8)
REQ-027 Motor request motor_id=7 -> one pulse with index 0, value 7; busy for 9 cycles; motor_ready high for exactly 1 cycle.
REQ-028 Disp request disp_bin=305 -> pulses (1,3), (2,0), (3,5); pulses spaced at least 9 cycles apart; first pulse no more than 20 cycles after acceptance.
REQ-029 motor_valid and disp_valid asserted in the same cycle, twice -> order is motor, disp, then disp, motor.
REQ-030 disp_bin=1023 and motor_id=12 -> digits written are 9,9,9 and 9.
REQ-031 With LCD_ARB_SKIP_UNCHANGED_EN: disp_bin=305 sent twice -> the second request produces 0 pulses; disp_bin=315 -> only the pulse (2,1).
REQ-032 sys_rst_n driven low between the first and second pulse of disp_bin=305 -> no further pulses, all outputs 0; a motor request after reset is served normally.
